// File: rtl/pipe_stage_reg.sv
// Purpose: parametrised inter-stage pipeline register (data words, ctrl bundle, wb address).
// Latency: 1 cycle from push to output; the skid entry adds no latency on the normal path.
// Backpressure: SKID=0 gives combinational ready_o; SKID=1 gives a 2-entry skid with registered ready_o.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), asynchronous active-high reset
//   valid_i / ready_o            upstream handshake
//   data_i, ctrl_i, addr_i       upstream entry (NUM_DATA words, word k at [k*DATA_W +: DATA_W])
//   stall_i                      hazard stall, blocks pop regardless of ready_i
//   flush_i                      synchronous flush, kills every held entry and any push this cycle
//   valid_o / ready_i            downstream handshake
//   data_o, ctrl_o, addr_o       output entry; ctrl_o is forced to 0 while valid_o=0
//   count_o                      held entries (0..2)
module pipe_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int CTRL_W   = 2,
  parameter int ADDR_W   = 5,
  parameter int SKID     = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [NUM_DATA*DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [NUM_DATA*DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [ADDR_W-1:0]          addr_o,
  output logic [1:0]                 count_o
);

  localparam int DW = NUM_DATA * DATA_W;

  logic              out_rdy;
  logic              push;
  logic              pop;
  logic [CTRL_W-1:0] ctrl_held;

  assign out_rdy = ready_i & ~stall_i;
  assign pop     = valid_o & out_rdy;
  assign push    = valid_i & ready_o & ~flush_i;

  // A bubble must never assert RegWrite or any other control bit.
  assign ctrl_o  = valid_o ? ctrl_held : '0;

  if (SKID == 0) begin : g_single

    logic              valid_q, valid_d;
    logic [DW-1:0]     data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      addr_d  = addr_q;
      if (flush_i) begin
        valid_d = 1'b0;
      end else if (push) begin
        // Covers push-with-pop too: the new entry replaces the departing one.
        valid_d = 1'b1;
        data_d  = data_i;
        ctrl_d  = ctrl_i;
        addr_d  = addr_i;
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        ctrl_q  <= '0;
        addr_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        ctrl_q  <= ctrl_d;
        addr_q  <= addr_d;
      end
    end

    // Ready depends combinationally on downstream ready and stall.
    assign ready_o   = ~valid_q | out_rdy;
    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign ctrl_held = ctrl_q;
    assign addr_o    = addr_q;
    assign count_o   = {1'b0, valid_q};

  end else begin : g_skid

    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL1 = 2'd1,
      FULL2 = 2'd2
    } state_t;

    state_t            state_q, state_d;

    // Main register always drives the outputs; skid holds the second (younger) entry.
    logic [DW-1:0]     main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [ADDR_W-1:0] main_addr_q, main_addr_d;
    logic [DW-1:0]     skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;

    always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      main_addr_d = main_addr_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_addr_d = skid_addr_q;

      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = FULL1;
            main_data_d = data_i;
            main_ctrl_d = ctrl_i;
            main_addr_d = addr_i;
          end
        end
        FULL1: begin
          if (push && pop) begin
            main_data_d = data_i;
            main_ctrl_d = ctrl_i;
            main_addr_d = addr_i;
          end else if (push) begin
            state_d     = FULL2;
            skid_data_d = data_i;
            skid_ctrl_d = ctrl_i;
            skid_addr_d = addr_i;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL2: begin
          // No push can arrive here: ready_o is low in this state.
          if (pop) begin
            state_d     = FULL1;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            main_addr_d = skid_addr_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase

      // Flush outranks stall and pop; stale register contents are harmless
      // because valid_o drops and ctrl_o is gated.
      if (flush_i) begin
        state_d = EMPTY;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        main_data_q <= '0;
        main_ctrl_q <= '0;
        main_addr_q <= '0;
        skid_data_q <= '0;
        skid_ctrl_q <= '0;
        skid_addr_q <= '0;
      end else begin
        main_data_q <= main_data_d;
        main_ctrl_q <= main_ctrl_d;
        main_addr_q <= main_addr_d;
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_addr_q <= skid_addr_d;
      end
    end

    // Ready is a pure function of registered state, breaking the ready path.
    assign ready_o   = (state_q != FULL2);
    assign valid_o   = (state_q != EMPTY);
    assign data_o    = main_data_q;
    assign ctrl_held = main_ctrl_q;
    assign addr_o    = main_addr_q;
    assign count_o   = state_q;

  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  c;
    logic [4:0]  a;
  } ent_t;

  typedef struct packed {
    logic [191:0] d;
    logic [4:0]   c;
    logic [5:0]   a;
  } went_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: output entry with no expected entry queued", nm);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: default widths, SKID=1 ----------------
  logic        a_vi = 1'b0, a_ri = 1'b0, a_stall = 1'b0, a_flush = 1'b0;
  logic [63:0] a_di = '0;
  logic [1:0]  a_ci = '0;
  logic [4:0]  a_ai = '0;
  logic        a_ro, a_vo;
  logic [63:0] a_do;
  logic [1:0]  a_co, a_cnt;
  logic [4:0]  a_ao;
  ent_t        qa[$];

  pipe_stage_reg #(.SKID(1)) u_a (
    .clk_i(clk), .rst_i(rst), .valid_i(a_vi), .ready_o(a_ro),
    .data_i(a_di), .ctrl_i(a_ci), .addr_i(a_ai), .stall_i(a_stall), .flush_i(a_flush),
    .valid_o(a_vo), .ready_i(a_ri), .data_o(a_do), .ctrl_o(a_co), .addr_o(a_ao), .count_o(a_cnt)
  );

  // ---------------- instance B: default widths, SKID=0 ----------------
  logic        b_vi = 1'b0, b_ri = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
  logic [63:0] b_di = '0;
  logic [1:0]  b_ci = '0;
  logic [4:0]  b_ai = '0;
  logic        b_ro, b_vo;
  logic [63:0] b_do;
  logic [1:0]  b_co, b_cnt;
  logic [4:0]  b_ao;
  ent_t        qb[$];

  pipe_stage_reg #(.SKID(0)) u_b (
    .clk_i(clk), .rst_i(rst), .valid_i(b_vi), .ready_o(b_ro),
    .data_i(b_di), .ctrl_i(b_ci), .addr_i(b_ai), .stall_i(b_stall), .flush_i(b_flush),
    .valid_o(b_vo), .ready_i(b_ri), .data_o(b_do), .ctrl_o(b_co), .addr_o(b_ao), .count_o(b_cnt)
  );

  // Scoreboard monitors: pop and compare whenever the DUT hands over an entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (!a_vo) chk("a_bubble_ctrl", a_co, 0);
      if (a_vo && a_ri && !a_stall && !a_flush) begin
        if (qa.size() == 0) fail_now("a_unexpected");
        else begin
          ent_t e;
          e = qa.pop_front();
          chk("a_out_data", a_do, e.d);
          chk("a_out_ctrl", a_co, e.c);
          chk("a_out_addr", a_ao, e.a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!b_vo) chk("b_bubble_ctrl", b_co, 0);
      if (b_vo && b_ri && !b_stall && !b_flush) begin
        if (qb.size() == 0) fail_now("b_unexpected");
        else begin
          ent_t e;
          e = qb.pop_front();
          chk("b_out_data", b_do, e.d);
          chk("b_out_ctrl", b_co, e.c);
          chk("b_out_addr", b_ao, e.a);
        end
      end
    end
  end

  task automatic a_set(input logic [63:0] d, input logic [1:0] c, input logic [4:0] ad, input bit acc);
    a_vi = 1'b1; a_di = d; a_ci = c; a_ai = ad;
    if (acc) qa.push_back('{d: d, c: c, a: ad});
  endtask

  task automatic b_set(input logic [63:0] d, input logic [1:0] c, input logic [4:0] ad);
    b_vi = 1'b1; b_di = d; b_ci = c; b_ai = ad;
    qb.push_back('{d: d, c: c, a: ad});
  endtask

  // ---------------- wide random sweep, both SKID values ----------------
  for (genvar g = 0; g < 2; g++) begin : gw
    logic         vi, ri, st, fl, ro, vo;
    logic [191:0] di, dout;
    logic [4:0]   ci, co;
    logic [5:0]   ai, ao;
    logic [1:0]   cnt;
    bit           done_w = 1'b0;
    went_t        q[$];

    pipe_stage_reg #(.DATA_W(64), .NUM_DATA(3), .CTRL_W(5), .ADDR_W(6), .SKID(g)) u_dut (
      .clk_i(clk), .rst_i(rst), .valid_i(vi), .ready_o(ro),
      .data_i(di), .ctrl_i(ci), .addr_i(ai), .stall_i(st), .flush_i(fl),
      .valid_o(vo), .ready_i(ri), .data_o(dout), .ctrl_o(co), .addr_o(ao), .count_o(cnt)
    );

    initial begin
      vi = 1'b0; ri = 1'b0; st = 1'b0; fl = 1'b0; di = '0; ci = '0; ai = '0;
      wait (run);
      while (run) begin
        tick();
        vi = 1'($urandom_range(0, 1));
        ri = ($urandom_range(0, 3) != 0);
        st = ($urandom_range(0, 3) == 0);
        di = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ci = 5'($urandom);
        ai = 6'($urandom);
      end
      vi = 1'b0; ri = 1'b1; st = 1'b0;
      repeat (6) tick();
      chk($sformatf("w%0d_drained", g), q.size(), 0);
      done_w = 1'b1;
    end

    always @(negedge clk) begin
      if (!rst) begin
        chk($sformatf("w%0d_count", g), cnt, q.size());
        chk($sformatf("w%0d_valid", g), vo, (q.size() != 0));
        chk($sformatf("w%0d_ready", g), ro,
            (g == 1) ? (q.size() < 2) : ((q.size() == 0) || (ri && !st)));
        if (!vo) chk($sformatf("w%0d_bubble_ctrl", g), co, 0);
        if (vo && ri && !st) begin
          if (q.size() == 0) fail_now($sformatf("w%0d_unexpected", g));
          else begin
            went_t e;
            e = q.pop_front();
            chk($sformatf("w%0d_data", g), dout, e.d);
            chk($sformatf("w%0d_ctrl", g), co, e.c);
            chk($sformatf("w%0d_addr", g), ao, e.a);
          end
        end
        if (vi && ro) q.push_back('{d: di, c: ci, a: ai});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_a_valid", a_vo, 0);
    chk("rst_a_ctrl",  a_co, 0);
    chk("rst_a_data",  a_do, 0);
    chk("rst_a_addr",  a_ao, 0);
    chk("rst_a_count", a_cnt, 0);
    chk("rst_a_ready", a_ro, 1);
    chk("rst_b_valid", b_vo, 0);
    chk("rst_b_ready", b_ro, 1);
    chk("rst_b_count", b_cnt, 0);
    repeat (2) tick();
    rst = 1'b0;

    // Stream one entry, SKID=1.
    a_ri = 1'b1;
    a_set({32'h22, 32'h11}, 2'b11, 5'd7, 1'b1);
    tick();
    a_vi = 1'b0;
    chk("t1_valid", a_vo, 1);
    chk("t1_data",  a_do, 64'h00000022_00000011);
    chk("t1_ctrl",  a_co, 2'b11);
    chk("t1_addr",  a_ao, 5'd7);
    chk("t1_count", a_cnt, 1);
    tick();
    chk("t1_count_after", a_cnt, 0);

    // Backpressure fill then drain.
    a_ri = 1'b0;
    a_set(64'hA, 2'b01, 5'd1, 1'b1);
    tick();
    a_set(64'hB, 2'b10, 5'd2, 1'b1);
    tick();
    a_vi = 1'b0;
    chk("t2_count2", a_cnt, 2);
    chk("t2_ready0", a_ro, 0);
    chk("t2_showsA", a_do, 64'hA);
    a_ri = 1'b1;
    tick();
    chk("t2_count1", a_cnt, 1);
    chk("t2_showsB", a_do, 64'hB);
    tick();
    chk("t2_count0", a_cnt, 0);

    // Flush in FULL1 with a real simultaneous push: both entries vanish.
    a_ri = 1'b0;
    a_set(64'hF0, 2'b11, 5'd3, 1'b1);
    tick();
    a_set(64'hF1, 2'b11, 5'd4, 1'b0);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_vi = 1'b0;
    qa.delete();
    chk("t3_valid", a_vo, 0);
    chk("t3_count", a_cnt, 0);
    a_ri = 1'b1;
    repeat (2) tick();

    // Flush in FULL2 with valid_i asserted.
    a_ri = 1'b0;
    a_set(64'hC, 2'b01, 5'd5, 1'b1);
    tick();
    a_set(64'hD, 2'b01, 5'd6, 1'b1);
    tick();
    chk("t4_count2", a_cnt, 2);
    a_set(64'hE, 2'b11, 5'd8, 1'b0);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_vi = 1'b0;
    qa.delete();
    chk("t4_valid", a_vo, 0);
    chk("t4_ctrl",  a_co, 0);
    chk("t4_count", a_cnt, 0);
    chk("t4_ready", a_ro, 1);
    a_ri = 1'b1;
    repeat (3) tick();
    chk("t4_still_empty", a_cnt, 0);

    // Asynchronous reset between edges while FULL2.
    a_ri = 1'b0;
    a_set(64'h48, 2'b11, 5'd9, 1'b1);
    tick();
    a_set(64'h49, 2'b11, 5'd10, 1'b1);
    tick();
    a_vi = 1'b0;
    chk("t5_count2", a_cnt, 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", a_vo, 0);
    chk("t5_ctrl",  a_co, 0);
    chk("t5_count", a_cnt, 0);
    qa.delete();
    tick();
    rst = 1'b0;
    a_set(64'h4A, 2'b10, 5'd11, 1'b1);
    tick();
    a_vi = 1'b0;
    chk("t5_first_push_valid", a_vo, 1);
    chk("t5_first_push_data",  a_do, 64'h4A);
    a_ri = 1'b1;
    tick();
    chk("t5_drained", a_cnt, 0);

    // Stall, SKID=0.
    b_ri = 1'b1;
    b_set(64'h5A5A, 2'b11, 5'd12);
    tick();
    b_vi = 1'b0;
    b_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_stall_valid", b_vo, 1);
      chk("t6_stall_ready", b_ro, 0);
      chk("t6_stall_data",  b_do, 64'h5A5A);
      tick();
    end
    b_stall = 1'b0;
    #1;
    chk("t6_unstall_ready", b_ro, 1);
    tick();
    chk("t6_popped", b_vo, 0);

    // SKID=0 back-to-back push with pop keeps count 1 and shows the new entry.
    b_set(64'h61, 2'b01, 5'd13);
    tick();
    b_set(64'h62, 2'b10, 5'd14);
    tick();
    b_vi = 1'b0;
    chk("t7_count", b_cnt, 1);
    chk("t7_data",  b_do, 64'h62);
    tick();

    // SKID=0 downstream not ready: combinational ready drops.
    b_ri = 1'b0;
    b_set(64'h71, 2'b11, 5'd15);
    tick();
    b_vi = 1'b0;
    chk("t8_ready0", b_ro, 0);
    chk("t8_count1", b_cnt, 1);
    b_ri = 1'b1;
    tick();
    chk("t8_count0", b_cnt, 0);

    // Random sweep.
    run = 1'b1;
    repeat (1500) @(posedge clk);
    run = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!(gw[0].done_w && gw[1].done_w) && waited < 100) begin
        @(posedge clk);
        waited++;
      end
      if (!(gw[0].done_w && gw[1].done_w)) begin
        n_chk++;
        n_fail++;
        $display("FAIL sweep_timeout: done=%0b%0b, required 11", gw[1].done_w, gw[0].done_w);
      end
    end
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
